risc16_mc_ctrl: RTL

RISC16_MC_CTRL -- requirements
Module: risc16_mc_ctrl

---
 rtl/risc16_mc_ctrl.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/risc16_mc_ctrl.sv
// Multi-cycle RiSC-16 control unit: FETCH/DECODE/EXEC/MEM/WB sequencer with an
// 8x16 register file, driving external instruction memory, data memory and ALU.
module risc16_mc_ctrl (
  input  logic        clk,
  input  logic        reset_n,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic        imem_ack,
  input  logic [15:0] imem_rdata,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [15:0] dmem_addr,
  output logic [15:0] dmem_wdata,
  input  logic        dmem_ack,
  input  logic [15:0] dmem_rdata,
  output logic [15:0] alu_src1,
  output logic [15:0] alu_src2,
  output logic [1:0]  alu_func,
  input  logic [15:0] alu_out,
  input  logic        alu_eq,
  output logic [15:0] pc,
  output logic        halt
);

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
  } state_e;

  typedef enum logic [2:0] {
    OP_ADD  = 3'b000, OP_ADDI = 3'b001, OP_NAND = 3'b010, OP_LUI  = 3'b011,
    OP_SW   = 3'b100, OP_LW   = 3'b101, OP_BEQ  = 3'b110, OP_JALR = 3'b111
  } op_e;

  localparam logic [1:0] FN_ADD  = 2'b00;
  localparam logic [1:0] FN_NAND = 2'b01;
  localparam logic [1:0] FN_LUI  = 2'b10;
  localparam logic [1:0] FN_PASS = 2'b11;

  state_e      state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic [15:0] ir_q, ir_d;
  logic [15:0] opa_q, opa_d;
  logic [15:0] opb_q, opb_d;
  logic [15:0] res_q, res_d;
  logic        z_q, z_d;
  logic [15:0] rf_q [8];
  logic        wr_en;
  logic [15:0] wr_data;

  op_e         op;
  logic [2:0]  ra, rb, rc;
  logic [15:0] simm;
  logic [9:0]  imm10;
  logic [15:0] r_a, r_b, r_c;
  logic        is_halt;

  assign op    = op_e'(ir_q[15:13]);
  assign ra    = ir_q[12:10];
  assign rb    = ir_q[9:7];
  assign rc    = ir_q[2:0];
  assign simm  = {{9{ir_q[6]}}, ir_q[6:0]};
  assign imm10 = ir_q[9:0];

  // r0 is hard-wired to zero on the read side; its storage is never written.
  assign r_a = (ra == 3'd0) ? 16'h0000 : rf_q[ra];
  assign r_b = (rb == 3'd0) ? 16'h0000 : rf_q[rb];
  assign r_c = (rc == 3'd0) ? 16'h0000 : rf_q[rc];

  assign is_halt = (op == OP_JALR) && (ra == 3'd0) && (rb == 3'd0) && (ir_q[6:0] != 7'd0);

  // NOTE: every variable gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    res_d   = res_q;
    z_d     = z_q;
    wr_en   = 1'b0;
    wr_data = res_q;
    case (state_q)
      S_FETCH: if (imem_ack) begin
        ir_d    = imem_rdata;
        state_d = S_DECODE;
      end
      S_DECODE: begin
        opa_d = (op == OP_BEQ) ? r_a : r_b;
        case (op)
          OP_ADD, OP_NAND: opb_d = r_c;
          OP_BEQ:          opb_d = r_b;
          OP_SW:           opb_d = r_a;
          default:         opb_d = 16'h0000;
        endcase
        state_d = S_EXEC;
      end
      S_EXEC: begin
        res_d = alu_out;
        z_d   = alu_eq;
        if (is_halt)                        state_d = S_HALT;
        else if (op == OP_LW || op == OP_SW) state_d = S_MEM;
        else                                state_d = S_WB;
      end
      S_MEM: if (dmem_ack) begin
        if (op == OP_LW) res_d = dmem_rdata;
        state_d = S_WB;
      end
      S_WB: begin
        state_d = S_FETCH;
        pc_d    = pc_q + 16'd1;
        case (op)
          OP_ADD, OP_ADDI, OP_NAND, OP_LUI, OP_LW: wr_en = 1'b1;
          OP_JALR: begin
            wr_en   = 1'b1;
            wr_data = pc_q + 16'd1;
            pc_d    = opa_q;
          end
          OP_BEQ:  if (z_q) pc_d = pc_q + 16'd1 + simm;
          default: ;
        endcase
        if (ra == 3'd0) wr_en = 1'b0;
      end
      S_HALT:  ;
      default: state_d = S_FETCH;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the values from before this edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_FETCH;
      pc_q    <= '0;
      ir_q    <= '0;
      opa_q   <= '0;
      opb_q   <= '0;
      res_q   <= '0;
      z_q     <= 1'b0;
      // NOTE: the register file is small and must read zero after reset, so it
      // is built from resettable flops rather than an un-reset RAM.
      for (int i = 0; i < 8; i++) rf_q[i] <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      res_q   <= res_d;
      z_q     <= z_d;
      if (wr_en) rf_q[ra] <= wr_data;
    end
  end

  always_comb begin
    alu_src1 = 16'h0000;
    alu_src2 = 16'h0000;
    alu_func = FN_PASS;
    if (state_q == S_EXEC) begin
      case (op)
        OP_ADD:  begin alu_src1 = opa_q; alu_src2 = opb_q; alu_func = FN_ADD;  end
        OP_ADDI: begin alu_src1 = opa_q; alu_src2 = simm;  alu_func = FN_ADD;  end
        OP_NAND: begin alu_src1 = opa_q; alu_src2 = opb_q; alu_func = FN_NAND; end
        OP_LUI:  begin alu_src2 = {imm10, 6'b0};           alu_func = FN_LUI;  end
        OP_LW,
        OP_SW:   begin alu_src1 = opa_q; alu_src2 = simm;  alu_func = FN_ADD;  end
        OP_BEQ:  begin alu_src1 = opa_q; alu_src2 = opb_q; alu_func = FN_ADD;  end
        OP_JALR: begin alu_src1 = opa_q;                   alu_func = FN_PASS; end
        default: ;
      endcase
    end
  end

  // Requests are gated by reset_n so an outstanding access drops the moment
  // reset asserts, without waiting for a clock edge.
  assign imem_req   = reset_n && (state_q == S_FETCH);
  assign imem_addr  = pc_q;
  assign dmem_req   = reset_n && (state_q == S_MEM);
  assign dmem_we    = dmem_req && (op == OP_SW);
  assign dmem_addr  = dmem_req ? res_q : 16'h0000;
  assign dmem_wdata = dmem_we ? opb_q : 16'h0000;
  assign pc         = pc_q;
  assign halt       = (state_q == S_HALT);

endmodule
